// File: rtl/backprop_sequencer.sv
// backprop_sequencer
//
// Sequences one backpropagation pass for a single training sample. It issues
// the sample index, the final-layer activation z, the descending layer indices
// and the per-layer z_prev vectors to the backpropagator. It then forwards the
// updated-weight stream that comes back, tagged with its layer, toward the
// forward-pass weight store.
//
// An internal activation store with LAYER_MAX+1 slots is written by the forward
// pass. Slot 0 holds the network input and slot LAYER_MAX the network output.
//
// Handshake rule for every stream: a token transfers on a rising clk edge where
// valid and ready are both 1. Once valid is asserted, it and its data stay
// stable until that transfer. The producer never waits on ready before
// asserting valid.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   act_wr_en/addr/data            activation store write (accepted in IDLE only)
//   start_sample/valid/ready       start command
//   sample/_valid/_ready           sample index token
//   z/_valid/_ready                final-layer activation token
//   layer/_valid/_ready            layer indices LAYER_MAX-1 .. 0
//   z_prev/_valid/_ready           activation of slot k for layer k
//   weights/_valid/_ready          updated weights from the backpropagator
//   w_out/_layer/_valid/_ready     weights forwarded with their layer tag
//   busy                           pass in progress
//   done                           one-cycle pulse at the end of a pass
//   error                          sticky illegal activation write
//   fsm_state                      current FSM state (debug)
module backprop_sequencer #(
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int WEIGHT_CELL_WIDTH   = 16,
  parameter int LAYER_ADDR_WIDTH    = 2,
  parameter int LAYER_MAX           = 3,
  parameter int SAMPLE_ADDR_SIZE    = 10
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            act_wr_en,
  input  logic [LAYER_ADDR_WIDTH-1:0]                     act_wr_addr,
  input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]       act_wr_data,
  input  logic [SAMPLE_ADDR_SIZE-1:0]                     start_sample,
  input  logic                                            start_valid,
  output logic                                            start_ready,
  output logic [SAMPLE_ADDR_SIZE-1:0]                     sample,
  output logic                                            sample_valid,
  input  logic                                            sample_ready,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]       z,
  output logic                                            z_valid,
  input  logic                                            z_ready,
  output logic [LAYER_ADDR_WIDTH-1:0]                     layer,
  output logic                                            layer_valid,
  input  logic                                            layer_ready,
  output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]       z_prev,
  output logic                                            z_prev_valid,
  input  logic                                            z_prev_ready,
  input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weights,
  input  logic                                            weights_valid,
  output logic                                            weights_ready,
  output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] w_out,
  output logic [LAYER_ADDR_WIDTH-1:0]                     w_out_layer,
  output logic                                            w_out_valid,
  input  logic                                            w_out_ready,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            error,
  output logic [1:0]                                      fsm_state
);

  localparam int ZW = NEURON_NUM * NEURON_OUTPUT_WIDTH;
  localparam logic [LAYER_ADDR_WIDTH-1:0] LM  = LAYER_ADDR_WIDTH'(LAYER_MAX);
  localparam logic [LAYER_ADDR_WIDTH-1:0] LM1 = LAYER_ADDR_WIDTH'(LAYER_MAX - 1);
  localparam logic [LAYER_ADDR_WIDTH-1:0] ONE = LAYER_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [ZW-1:0]               act_mem [LAYER_MAX+1];
  logic [LAYER_ADDR_WIDTH-1:0] zp_cnt;   // slot index behind the current z_prev
  logic [LAYER_ADDR_WIDTH-1:0] w_cnt;    // layer tag of the next weight token
  logic [LAYER_ADDR_WIDTH-1:0] w_left;   // weight tokens still expected

  // The address is widened by one bit so that the range check stays a real
  // comparison even when LAYER_MAX is the largest encodable index.
  logic wr_addr_ok;
  logic wr_ok;
  assign wr_addr_ok = ({1'b0, act_wr_addr} <= (LAYER_ADDR_WIDTH+1)'(LAYER_MAX));
  assign wr_ok      = wr_addr_ok && (state == IDLE);

  // A write landing in the same cycle as the start accept is forwarded, so the
  // pass sees the new data (write-first).
  logic [ZW-1:0] z_load;
  logic [ZW-1:0] zp_load;
  assign z_load  = (act_wr_en && wr_ok && (act_wr_addr == LM))  ? act_wr_data
                                                                 : act_mem[LAYER_MAX];
  assign zp_load = (act_wr_en && wr_ok && (act_wr_addr == LM1)) ? act_wr_data
                                                                 : act_mem[LAYER_MAX-1];

  logic [LAYER_ADDR_WIDTH-1:0] zp_next_idx;
  assign zp_next_idx = zp_cnt - ONE;

  // Handshakes
  logic start_fire, sample_fire, z_fire, layer_fire, zp_fire, w_fire;
  assign start_ready = (state == IDLE);
  assign start_fire  = start_valid && start_ready;
  assign sample_fire = sample_valid && sample_ready;
  assign z_fire      = z_valid && z_ready;
  assign layer_fire  = layer_valid && layer_ready;
  assign zp_fire     = z_prev_valid && z_prev_ready;

  // Weight return is a pure pass-through gated by the pass state.
  assign w_out         = weights;
  assign w_out_layer   = w_cnt;
  assign w_out_valid   = weights_valid && (state == RUN);
  assign weights_ready = w_out_ready && (state == RUN) && (w_left != '0);
  assign w_fire        = weights_valid && weights_ready;

  // A channel counts as finished if it has already drained or drains at this
  // edge; looking ahead this way lets done follow the last token by one cycle.
  logic sample_fin, z_fin, layer_fin, zp_fin, w_fin, all_fin;
  assign sample_fin = !sample_valid || sample_fire;
  assign z_fin      = !z_valid || z_fire;
  assign layer_fin  = !layer_valid || (layer_fire && (layer == '0));
  assign zp_fin     = !z_prev_valid || (zp_fire && (zp_cnt == '0));
  assign w_fin      = (w_left == '0) || (w_fire && (w_left == ONE));
  assign all_fin    = sample_fin && z_fin && layer_fin && zp_fin && w_fin;

  assign fsm_state = state;

  // Activation store and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= LAYER_MAX; i++) begin
        act_mem[i] <= '0;
      end
      error <= 1'b0;
    end else if (act_wr_en) begin
      if (wr_ok) begin
        act_mem[act_wr_addr] <= act_wr_data;
      end else begin
        error <= 1'b1;
      end
    end
  end

  // Pass sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sample       <= '0;
      sample_valid <= 1'b0;
      z            <= '0;
      z_valid      <= 1'b0;
      layer        <= '0;
      layer_valid  <= 1'b0;
      z_prev       <= '0;
      z_prev_valid <= 1'b0;
      zp_cnt       <= '0;
      w_cnt        <= '0;
      w_left       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_fire) begin
            sample       <= start_sample;
            sample_valid <= 1'b1;
            z            <= z_load;
            z_valid      <= 1'b1;
            layer        <= LM1;
            layer_valid  <= 1'b1;
            zp_cnt       <= LM1;
            z_prev       <= zp_load;
            z_prev_valid <= 1'b1;
            w_cnt        <= LM1;
            w_left       <= LM;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end

        RUN: begin
          if (sample_fire) sample_valid <= 1'b0;
          if (z_fire)      z_valid      <= 1'b0;

          if (layer_fire) begin
            if (layer == '0) layer_valid <= 1'b0;
            else             layer       <= layer - ONE;
          end

          if (zp_fire) begin
            if (zp_cnt == '0) begin
              z_prev_valid <= 1'b0;
            end else begin
              zp_cnt <= zp_next_idx;
              z_prev <= act_mem[zp_next_idx];
            end
          end

          if (w_fire) begin
            w_left <= w_left - ONE;
            if (w_cnt != '0) w_cnt <= w_cnt - ONE;
          end

          if (all_fin) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/backprop_sequencer.md
Name: backprop_sequencer

Overview:
- Drives one backpropagation pass for a single training sample: issues the sample index, the final-layer output z, the descending layer indices and per-layer z_prev vectors to the backpropagator streams.
- Consumes the updated-weight stream coming back and forwards it, tagged with its layer, toward the forward-pass weight store.
- Holds an internal activation store of LAYER_MAX+1 slots, written by the forward pass. Slot 0 is the network input; slot LAYER_MAX is the network output.

Parameters:
- NEURON_NUM, 5, neurons per layer
- NEURON_OUTPUT_WIDTH, 10, width of one z cell
- WEIGHT_CELL_WIDTH, 16, width of one weight cell
- LAYER_ADDR_WIDTH, 2, layer index width; requires LAYER_MAX < 2**LAYER_ADDR_WIDTH
- LAYER_MAX, 3, number of weight layers
- SAMPLE_ADDR_SIZE, 10, sample index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- act_wr_en  in  1  activation store write strobe
- act_wr_addr  in  LAYER_ADDR_WIDTH  slot 0..LAYER_MAX
- act_wr_data  in  NEURON_NUM*NEURON_OUTPUT_WIDTH  activation vector
- start_sample  in  SAMPLE_ADDR_SIZE  sample to train on
- start_valid  in  1  / start_ready  out  1  start command handshake
- sample  out  SAMPLE_ADDR_SIZE  / sample_valid  out  1 / sample_ready  in  1
- z  out  NEURON_NUM*NEURON_OUTPUT_WIDTH  / z_valid  out  1 / z_ready  in  1
- layer  out  LAYER_ADDR_WIDTH  / layer_valid  out  1 / layer_ready  in  1
- z_prev  out  NEURON_NUM*NEURON_OUTPUT_WIDTH  / z_prev_valid  out  1 / z_prev_ready  in  1
- weights  in  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  / weights_valid  in  1 / weights_ready  out  1
- w_out  out  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  / w_out_layer  out  LAYER_ADDR_WIDTH / w_out_valid  out  1 / w_out_ready  in  1
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass end
- error  out  1  sticky: activation write during pass, or address > LAYER_MAX

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state:
  - state=IDLE; all *_valid=0, busy=0, done=0, error=0.
  - All counters 0; activation store cleared to 0; all data outputs 0.
- Activation store: register array, slots 0..LAYER_MAX.
  - A write is performed when act_wr_en=1, state=IDLE and act_wr_addr<=LAYER_MAX.
  - Otherwise the write is dropped and error is set. error clears only on rst.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready: latch start_sample; load sample and z (=slot LAYER_MAX); load layer and z_prev counters to LAYER_MAX-1 and z_prev to slot LAYER_MAX-1; clear the weight counter to LAYER_MAX-1.
  - Assert sample_valid, z_valid, layer_valid and z_prev_valid the next cycle; go to RUN; busy=1 from that cycle.
  - An act write in the same cycle as an accepted start lands before z/z_prev are loaded (write-first).
- RUN: four independent output channels plus a return channel. A valid, once asserted, holds with stable data until ready.
  - sample, z: single token each; valid drops the cycle after handshake.
  - layer: emits LAYER_MAX-1 down to 0, one per handshake. The next value is presented the cycle after the handshake, so there is no bubble when ready is held high. After emitting 0, valid drops.
  - z_prev: same sequencing as layer, but carries slot k for layer k. Its counter is independent of the layer channel.
  - Weight return: combinational pass-through, with no storage.
    - w_out=weights, w_out_layer=weight counter.
    - w_out_valid=weights_valid&(state==RUN).
    - weights_ready=w_out_ready&(state==RUN)&(weight tokens remaining).
    - Each handshake decrements the weight counter.
  - Go to DONE when all sample, z, layer and z_prev tokens are issued and LAYER_MAX weight tokens have passed.
- DONE: done=1 for exactly one cycle, busy=0; next cycle IDLE. start_ready=0 in RUN and DONE.
- Weights arriving in IDLE/DONE are not accepted (weights_ready=0).
- Counters never wrap below 0. Extra ready pulses after a channel finishes have no effect.
- Reset mid-pass: abandons the pass immediately and returns to the reset state next cycle; the activation store is cleared.
- Latency: start accept to first layer/z_prev/sample/z valid = 1 cycle. Last weight handshake to done = 1 cycle.

Test Plan:
- Basic pass, all readies held 1 (LAYER_MAX=3, NEURON_NUM=2, 10-bit cells):
  - Stimulus: write slots 0..3 with 0x001_002, 0x003_004, 0x005_006, 0x007_008; start sample 42; weights returned with valid held 1.
  - Response: sample=42 once; z=0x007_008 once; layer 2,1,0 on consecutive cycles; z_prev 0x005_006, 0x003_004, 0x001_002; w_out_layer 2,1,0; done pulses 1 cycle after third weight handshake.
- Backpressure:
  - Stimulus: random ready stalls on layer, z_prev and w_out (w_out_ready=0 for 5 cycles).
  - Response: held data stable while valid && !ready; no token lost or duplicated; weights_ready=0 while w_out_ready=0.
- Illegal activation write:
  - Stimulus: act_wr_en during RUN to slot 1; act_wr_addr=3 with LAYER_MAX=2.
  - Response: error=1 sticky; slot contents unchanged; pass completes normally.
- Start during busy and write-first:
  - Stimulus: start_valid held through a pass; act write to slot 3 in the same cycle as start accept.
  - Response: start_ready=0 in RUN/DONE; second start accepted the cycle after returning to IDLE; first pass's z equals the new slot-3 value.
- Reset mid-pass:
  - Stimulus: rst after layer 2 issued.
  - Response: all valids 0, busy=0, store reads 0; next start restarts from layer LAYER_MAX-1.
- Spurious weights:
  - Stimulus: weights_valid=1 in IDLE.
  - Response: weights_ready=0, w_out_valid=0.
